synaptic_current_gen: RTL and testbench

- Receiving end of the spike interface: converts incoming spike events into the 8-bit synaptic current that drives a downstream neuron's current input.
- Each of N_IN spike lines carries a programmable weight. Weights of all spiking inputs are summed into a saturating accumulator.
- The accumulator decays exponentially (shift-subtract) at a fixed cycle interval.
- Sits between an upstream spiking layer and the next neuron.

---
 rtl/snn_pkg.sv | 22 ++
 rtl/syn_weight_rf.sv | 49 ++++
 rtl/synaptic_current_gen.sv | 131 +++++++++++++
 tb/tb_synaptic_current_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network blocks.
//   DEF_W_WIDTH / DEF_ACC_WIDTH : default weight and accumulator widths
//   syn_state_e                 : synapse FSM states
//   saturate()                  : clamp an unsigned value to a given bit width
package snn_pkg;

  localparam int unsigned DEF_W_WIDTH   = 8;
  localparam int unsigned DEF_ACC_WIDTH = 10;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } syn_state_e;

  // Clamp val to the largest value representable in `width` bits.
  function automatic logic [31:0] saturate(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/syn_weight_rf.sv
// Synaptic weight register file with a combinational weighted spike sum.
//   clk, rst  : clock and asynchronous active-high reset (weights clear to 0)
//   wr_en     : write strobe; wr_addr selects the weight, wr_data is the value
//   spike_in  : one spike line per weight
//   sum       : sum of the weights whose spike line is high (pre-write values)
module syn_weight_rf
  import snn_pkg::*;
#(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned W_WIDTH = DEF_W_WIDTH,
  parameter int unsigned ADDR_W  = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int unsigned SUM_W   = W_WIDTH + $clog2(N_IN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [W_WIDTH-1:0] wr_data,
  input  logic [N_IN-1:0]    spike_in,
  output logic [SUM_W-1:0]   sum
);

  logic [W_WIDTH-1:0] weight_q [N_IN];

  // Address decode by equality: indices at or beyond N_IN never match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) begin
        weight_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < N_IN; i++) begin
        if (wr_addr == ADDR_W'(i)) begin
          weight_q[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spike_in[i]) begin
        sum = sum + SUM_W'(weight_q[i]);
      end
    end
  end

endmodule

// File: rtl/synaptic_current_gen.sv
// Synaptic current generator: turns weighted spike events into an 8-bit current.
//   clk, rst  : clock and asynchronous active-high reset
//   enable    : 1 = integrate and decay, 0 = freeze accumulator/timer/FSM, drop spikes
//   spike_in  : presynaptic spike lines, one event per high cycle
//   wr_en, wr_addr, wr_data : weight write port (accepted regardless of enable)
//   current   : registered min(acc, 255)
//   active    : 1 while the FSM is ACTIVE
//   sat_flag  : sticky accumulator-saturation indicator
module synaptic_current_gen
  import snn_pkg::*;
#(
  parameter int unsigned N_IN         = 4,
  parameter int unsigned W_WIDTH      = DEF_W_WIDTH,
  parameter int unsigned ACC_WIDTH    = DEF_ACC_WIDTH,
  parameter int unsigned DECAY_SHIFT  = 3,
  parameter int unsigned DECAY_PERIOD = 4,
  localparam int unsigned ADDR_W  = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int unsigned SUM_W   = W_WIDTH + $clog2(N_IN) + 1,
  localparam int unsigned TIMER_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [N_IN-1:0]    spike_in,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [W_WIDTH-1:0] wr_data,
  output logic [7:0]         current,
  output logic               active,
  output logic               sat_flag
);

  syn_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_next, dec;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [7:0]           current_q, current_d;
  logic                 sat_flag_q, sat_flag_d;
  logic [SUM_W-1:0]     sum;
  logic                 tick, clamp;
  logic [31:0]          raw, clamped;

  syn_weight_rf #(
    .N_IN    (N_IN),
    .W_WIDTH (W_WIDTH),
    .ADDR_W  (ADDR_W),
    .SUM_W   (SUM_W)
  ) u_weight_rf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .spike_in (spike_in),
    .sum      (sum)
  );

  assign tick = (state_q == StActive) && enable && (timer_q == TIMER_W'(DECAY_PERIOD - 1));

  // Accumulator datapath. The decay step never drops below 1 on a non-zero
  // accumulator so the current always returns to exactly 0.
  always_comb begin
    dec = acc_q >> DECAY_SHIFT;
    if ((dec == '0) && (acc_q != '0)) begin
      dec = ACC_WIDTH'(1);
    end
    // dec <= acc_q, so the subtraction cannot wrap.
    raw      = 32'(acc_q) - (tick ? 32'(dec) : 32'd0) + 32'(sum);
    clamped  = saturate(raw, ACC_WIDTH);
    clamp    = (clamped != raw);
    acc_next = ACC_WIDTH'(clamped);
  end

  always_comb begin
    acc_d      = acc_q;
    sat_flag_d = sat_flag_q;
    if (enable) begin
      acc_d      = acc_next;
      sat_flag_d = sat_flag_q | clamp;
    end
    current_d = (acc_d > ACC_WIDTH'(255)) ? 8'hFF : acc_d[7:0];
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    if (enable) begin
      unique case (state_q)
        StIdle:   if (sum != '0)      state_d = StActive;
        StActive: if (acc_next == '0) state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Timer only runs while staying ACTIVE; entering or leaving ACTIVE restarts it at 0.
  always_comb begin
    timer_d = timer_q;
    if (enable) begin
      if ((state_q == StActive) && (state_d == StActive)) begin
        timer_d = tick ? '0 : timer_q + TIMER_W'(1);
      end else begin
        timer_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      timer_q    <= '0;
      current_q  <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      timer_q    <= timer_d;
      current_q  <= current_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  // FSM outputs, decoded from the state register.
  always_comb begin
    active = (state_q == StActive);
  end

  assign current  = current_q;
  assign sat_flag = sat_flag_q;

endmodule

// File: tb/tb_synaptic_current_gen.sv
module tb_synaptic_current_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] spike_in;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] current;
  logic       active;
  logic       sat_flag;

  synaptic_current_gen #(
    .N_IN         (4),
    .W_WIDTH      (8),
    .ACC_WIDTH    (10),
    .DECAY_SHIFT  (3),
    .DECAY_PERIOD (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .spike_in (spike_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .current  (current),
    .active   (active),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] cur;
    logic       act;
    logic       sat;
  } exp_t;

  typedef struct {
    string      tag;
    bit         rst_first;
    logic       en;
    logic [3:0] spk;
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [7:0] cur;
    logic       act;
    logic       sat;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // Scoreboard: each expectation is pushed on the edge that should produce it
  // and compared on the following falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.tag, " current"}, int'(current), int'(e.cur));
      check({e.tag, " active"}, int'(active), int'(e.act));
      check({e.tag, " sat_flag"}, int'(sat_flag), int'(e.sat));
    end
  end

  task automatic step(input string tag, input logic en, input logic [3:0] spk, input logic we,
                      input logic [1:0] wa, input logic [7:0] wd, input logic [7:0] cur,
                      input logic act, input logic sat);
    exp_t e;
    enable   = en;
    spike_in = spk;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    @(posedge clk);
    e.tag = tag;
    e.cur = cur;
    e.act = act;
    e.sat = sat;
    sb_q.push_back(e);
    #1;
  endtask

  // Mid-cycle asynchronous reset; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst      = 1'b1;
    enable   = 1'b1;
    spike_in = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    #1;
    check({tag, " current"}, int'(current), 0);
    check({tag, " active"}, int'(active), 0);
    check({tag, " sat_flag"}, int'(sat_flag), 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string tag, input bit rf, input logic en, input logic [3:0] spk,
                     input logic we, input logic [1:0] wa, input logic [7:0] wd,
                     input logic [7:0] cur, input logic act, input logic sat);
    vec_t v;
    v.tag = tag; v.rst_first = rf; v.en = en; v.spk = spk; v.we = we; v.wa = wa; v.wd = wd;
    v.cur = cur; v.act = act; v.sat = sat;
    tbl.push_back(v);
  endtask

  int chain[28] = '{64, 56, 49, 43, 38, 34, 30, 27, 24, 21, 19, 17, 15, 14,
                    13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};

  initial begin
    bit done;
    rst      = 1'b1;
    enable   = 1'b1;
    spike_in = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    #2;
    check("por current", int'(current), 0);
    check("por active", int'(active), 0);
    check("por sat_flag", int'(sat_flag), 0);
    #5;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero weights after reset: spikes do nothing.
    add("zero_w0", 1'b0, 1, 4'b1111, 0, 0, 0, 0, 0, 0);
    add("zero_w1", 1'b0, 1, 4'b1111, 0, 0, 0, 0, 0, 0);
    add("zero_w2", 1'b0, 1, 4'b1111, 0, 0, 0, 0, 0, 0);
    // Single spike of weight 64, first decay step 4 edges later.
    add("w64_wr",  1'b0, 1, 4'b0000, 1, 0, 64, 0, 0, 0);
    add("w64_spk", 1'b0, 1, 4'b0001, 0, 0, 0, 64, 1, 0);
    add("w64_t1",  1'b0, 1, 4'b0000, 0, 0, 0, 64, 1, 0);
    add("w64_t2",  1'b0, 1, 4'b0000, 0, 0, 0, 64, 1, 0);
    add("w64_t3",  1'b0, 1, 4'b0000, 0, 0, 0, 64, 1, 0);
    add("w64_dec", 1'b0, 1, 4'b0000, 0, 0, 0, 56, 1, 0);
    // Write and spike on the same index: old weight (10) used, new one (100) next.
    add("wrsp_wr",  1'b1, 1, 4'b0000, 1, 2, 10, 0, 0, 0);
    add("wrsp_old", 1'b0, 1, 4'b0100, 1, 2, 100, 10, 1, 0);
    add("wrsp_new", 1'b0, 1, 4'b0100, 0, 0, 0, 110, 1, 0);
    add("wrsp_t2",  1'b0, 1, 4'b0000, 0, 0, 0, 110, 1, 0);
    add("wrsp_t3",  1'b0, 1, 4'b0000, 0, 0, 0, 110, 1, 0);
    add("wrsp_dec", 1'b0, 1, 4'b0000, 0, 0, 0, 97, 1, 0);
    // Freeze with enable low: spikes dropped, no decay.
    add("frz_wr",  1'b1, 1, 4'b0000, 1, 0, 200, 0, 0, 0);
    add("frz_spk", 1'b0, 1, 4'b0001, 0, 0, 0, 200, 1, 0);
    add("frz_0",   1'b0, 0, 4'b1111, 0, 0, 0, 200, 1, 0);
    add("frz_1",   1'b0, 0, 4'b1111, 0, 0, 0, 200, 1, 0);
    add("frz_2",   1'b0, 0, 4'b1111, 0, 0, 0, 200, 1, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst_first) do_reset({tbl[i].tag, " rst"});
      step(tbl[i].tag, tbl[i].en, tbl[i].spk, tbl[i].we, tbl[i].wa, tbl[i].wd,
           tbl[i].cur, tbl[i].act, tbl[i].sat);
    end

    // Continue the freeze to 20 cycles, then reset mid-cycle.
    for (int i = 0; i < 17; i++) step("frz_n", 0, 4'b1111, 0, 0, 0, 200, 1, 0);
    do_reset("frz_rst");
    step("post_rst_spk", 1, 4'b0001, 0, 0, 0, 0, 0, 0);

    // Full decay chain from 64 down to 0, one step every 4 cycles.
    do_reset("chain rst");
    step("chain_wr", 1, 4'b0000, 1, 0, 64, 0, 0, 0);
    step("chain_spk", 1, 4'b0001, 0, 0, 0, 64, 1, 0);
    for (int m = 0; m < 27; m++) begin
      for (int c = 0; c < 3; c++) begin
        step($sformatf("chain_hold%0d", m), 1, 4'b0000, 0, 0, 0, 8'(chain[m]), 1, 0);
      end
      step($sformatf("chain_dec%0d", m + 1), 1, 4'b0000, 0, 0, 0, 8'(chain[m + 1]),
           chain[m + 1] != 0, 0);
    end
    for (int i = 0; i < 3; i++) step("chain_idle", 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    step("retrig_spk", 1, 4'b0001, 0, 0, 0, 64, 1, 0);
    for (int i = 0; i < 3; i++) step("retrig_hold", 1, 4'b0000, 0, 0, 0, 64, 1, 0);
    step("retrig_dec", 1, 4'b0000, 0, 0, 0, 56, 1, 0);

    // Spike on the edge the last decay step would reach 0: stays ACTIVE.
    do_reset("edge rst");
    step("edge_wr", 1, 4'b0000, 1, 0, 1, 0, 0, 0);
    step("edge_spk", 1, 4'b0001, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step("edge_hold", 1, 4'b0000, 0, 0, 0, 1, 1, 0);
    step("edge_tick_spk", 1, 4'b0001, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step("edge_hold2", 1, 4'b0000, 0, 0, 0, 1, 1, 0);
    step("edge_zero", 1, 4'b0000, 0, 0, 0, 0, 0, 0);

    // Saturation: 1020 then clamp at 1023; sat_flag survives decay to 0.
    do_reset("sat rst");
    for (int i = 0; i < 4; i++) step("sat_wr", 1, 4'b0000, 1, 2'(i), 255, 0, 0, 0);
    step("sat_1020", 1, 4'b1111, 0, 0, 0, 255, 1, 0);
    step("sat_1023", 1, 4'b1111, 0, 0, 0, 255, 1, 1);
    enable   = 1'b1;
    spike_in = '0;
    done     = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!active) done = 1'b1;
    end
    check("sat decay finished", int'(done), 1);
    check("sat end current", int'(current), 0);
    check("sat sticky", int'(sat_flag), 1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
